// File: rtl/k16_pkg.sv
// Shared definitions for the k16 memory subsystem: bus width and the
// read-return ownership encoding used by the arbiter.
package k16_pkg;

  localparam int K16_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    VID_RD = 2'd2,
    CPU_WR = 2'd3
  } k16_state_e;

endpackage

// File: rtl/k16_mem_arbiter.sv
// Single-port RAM arbiter between a CPU and a video fetcher.
// Video has priority, but after VID_MAX back-to-back video grants with the
// CPU waiting, the CPU gets one slot. Reads return one cycle after grant;
// the state register remembers who owns the returning data.
//
// state  | meaning
// IDLE   | nothing granted last cycle, no data returning
// CPU_RD | CPU read granted last cycle, capture mem_data_in into cpu_rdata
// VID_RD | video read granted last cycle, present mem_data_in on vid_data
// CPU_WR | CPU write granted last cycle, nothing returning
module k16_mem_arbiter
  import k16_pkg::*;
#(
  parameter int VID_MAX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req,
  input  logic             cpu_write,
  input  logic [K16_W-1:0] cpu_addr,
  input  logic [K16_W-1:0] cpu_wdata,
  output logic [K16_W-1:0] cpu_rdata,
  output logic             cpu_wait,
  input  logic             vid_req,
  input  logic [K16_W-1:0] vid_addr,
  output logic             vid_ack,
  output logic [K16_W-1:0] vid_data,
  output logic             vid_valid,
  output logic [K16_W-1:0] mem_address,
  output logic [K16_W-1:0] mem_data_out,
  output logic             mem_write,
  input  logic [K16_W-1:0] mem_data_in
);

  // At least one bit so VID_MAX=0 still yields a legal counter.
  localparam int RUN_W = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VID_MAX);

  k16_state_e       state_q, state_d;
  logic [RUN_W-1:0] vid_run_q, vid_run_d;
  logic [K16_W-1:0] mem_address_q, mem_address_d;
  logic [K16_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic             vid_capped;
  logic             vid_grant;
  logic             cpu_grant;

  // Grant decision: video first unless its streak has starved a waiting CPU.
  always_comb begin
    vid_capped = cpu_req && (vid_run_q == RUN_MAX);
    vid_grant  = reset_n && vid_req && !vid_capped;
    cpu_grant  = reset_n && cpu_req && !vid_grant;
  end

  // Next-state: return owner, streak counter, address hold, CPU read capture.
  always_comb begin
    state_d       = IDLE;
    vid_run_d     = vid_run_q;
    mem_address_d = mem_address_q;
    cpu_rdata_d   = cpu_rdata_q;

    if (vid_grant) begin
      state_d       = VID_RD;
      mem_address_d = vid_addr;
    end else if (cpu_grant) begin
      state_d       = cpu_write ? CPU_WR : CPU_RD;
      mem_address_d = cpu_addr;
    end

    if (!cpu_req || cpu_grant) begin
      vid_run_d = '0;
    end else if (vid_grant && (vid_run_q != RUN_MAX)) begin
      vid_run_d = vid_run_q + RUN_W'(1);
    end

    if (state_q == CPU_RD) begin
      cpu_rdata_d = mem_data_in;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      vid_run_q     <= '0;
      mem_address_q <= '0;
      cpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      vid_run_q     <= vid_run_d;
      mem_address_q <= mem_address_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

  // The granted address goes straight to the RAM; idle cycles hold the last one.
  assign mem_address  = mem_address_d;
  assign mem_data_out = cpu_wdata;
  assign mem_write    = cpu_grant && cpu_write;
  assign cpu_wait     = reset_n && cpu_req && !cpu_grant;
  assign vid_ack      = vid_grant;
  // Gating with reset_n drops a return that was in flight when reset arrived.
  assign vid_valid    = reset_n && (state_q == VID_RD);
  assign vid_data     = mem_data_in;
  assign cpu_rdata    = cpu_rdata_q;

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// Bench for k16_mem_arbiter: table vectors, directed corner sequences and a
// randomized run, all compared against a cycle-level reference model.
module tb_k16_mem_arbiter;
  import k16_pkg::*;

  localparam int VMAX = 4;

  logic        clk;
  logic        reset_n, cpu_req, cpu_write, vid_req;
  logic [15:0] cpu_addr, cpu_wdata, vid_addr, mem_data_in;
  logic [15:0] cpu_rdata, vid_data, mem_address, mem_data_out;
  logic        cpu_wait, vid_ack, vid_valid, mem_write;

  logic [15:0] z_cpu_rdata, z_vid_data, z_mem_address, z_mem_data_out;
  logic        z_cpu_wait, z_vid_ack, z_vid_valid, z_mem_write;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  k16_mem_arbiter #(.VID_MAX(VMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_write(mem_write), .mem_data_in(mem_data_in)
  );

  // Second instance with no video streak allowance: CPU always preempts.
  k16_mem_arbiter #(.VID_MAX(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_wait(z_cpu_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(z_vid_ack),
    .vid_data(z_vid_data), .vid_valid(z_vid_valid),
    .mem_address(z_mem_address), .mem_data_out(z_mem_data_out),
    .mem_write(z_mem_write), .mem_data_in(mem_data_in)
  );

  // Synchronous RAM: data for an address appears one cycle later.
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_data_out;
    mem_data_in <= ram[mem_address];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: streak count, last bus address, pending return, memory image.
  int          run = 0;
  logic [15:0] last_addr = 16'h0;
  bit          pend_vid = 0, pend_cpu = 0;
  logic [15:0] pend_data = 16'h0;
  logic [15:0] m_rdata = 16'h0;
  logic [15:0] mmem [0:65535];
  bit          e_vg, e_cg;
  logic [15:0] e_addr;

  task automatic drive(input logic rn, input logic cr, input logic cw,
                       input logic [15:0] ca, input logic [15:0] cwd,
                       input logic vr, input logic [15:0] va);
    reset_n = rn; cpu_req = cr; cpu_write = cw; cpu_addr = ca;
    cpu_wdata = cwd; vid_req = vr; vid_addr = va;
  endtask

  task automatic drive_idle(input logic rn);
    drive(rn, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ram[a]  = d;
    mmem[a] = d;
  endtask

  task automatic model_check();
    e_vg   = reset_n && vid_req && !(cpu_req && run == VMAX);
    e_cg   = reset_n && cpu_req && !e_vg;
    e_addr = e_vg ? vid_addr : (e_cg ? cpu_addr : last_addr);
    chk("vid_ack", vid_ack, e_vg);
    chk("cpu_wait", cpu_wait, reset_n && cpu_req && !e_cg);
    chk("mem_write", mem_write, e_cg && cpu_write);
    chk("mem_address", mem_address, e_addr);
    if (e_cg && cpu_write) chk("mem_data_out", mem_data_out, cpu_wdata);
    chk("vid_valid", vid_valid, reset_n && pend_vid);
    if (reset_n && pend_vid) chk("vid_data", vid_data, pend_data);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("vmax0_ack", z_vid_ack, reset_n && vid_req && !cpu_req);
    chk("vmax0_wait", z_cpu_wait, 1'b0);
  endtask

  task automatic model_update();
    if (!reset_n) begin
      run = 0; last_addr = 16'h0; pend_vid = 0; pend_cpu = 0; m_rdata = 16'h0;
    end else begin
      if (pend_cpu) m_rdata = pend_data;
      pend_vid  = e_vg;
      pend_cpu  = e_cg && !cpu_write;
      pend_data = mmem[e_addr];
      if (e_cg && cpu_write) mmem[cpu_addr] = cpu_wdata;
      if (!cpu_req || e_cg) run = 0;
      else if (e_vg && run < VMAX) run++;
      last_addr = e_addr;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rn, cr, cw;
    logic [15:0] ca, cwd;
    logic        vr;
    logic [15:0] va;
    logic        x_ack, x_wait, x_mw;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic rn, input logic cr, input logic cw,
                     input logic [15:0] ca, input logic [15:0] cwd,
                     input logic vr, input logic [15:0] va,
                     input logic xa, input logic xw, input logic xm);
    vec_t v;
    v.rn = rn; v.cr = cr; v.cw = cw; v.ca = ca; v.cwd = cwd; v.vr = vr; v.va = va;
    v.x_ack = xa; v.x_wait = xw; v.x_mw = xm;
    tab.push_back(v);
  endtask

  logic [15:0] sdat [4];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 16'h0;
      mmem[i] = 16'h0;
    end
    drive_idle(1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Table: reset, contention pattern, write, read-back.
    add(0, 1, 0, 16'h0005, 16'h0, 1, 16'h0100, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      add(1, 1, 0, 16'h0005, 16'h0, 1, 16'h0100 + 16'(i),
          (i % 5) != 4, (i % 5) != 4, 0);
    end
    add(1, 1, 1, 16'h0020, 16'hBEEF, 0, 16'h0, 0, 0, 1);
    add(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0);
    add(1, 1, 0, 16'h0020, 16'h0, 0, 16'h0, 0, 0, 0);
    add(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0);
    foreach (tab[i]) begin
      drive(tab[i].rn, tab[i].cr, tab[i].cw, tab[i].ca, tab[i].cwd, tab[i].vr, tab[i].va);
      @(negedge clk);
      chk($sformatf("tab%0d_ack", i), vid_ack, tab[i].x_ack);
      chk($sformatf("tab%0d_wait", i), cpu_wait, tab[i].x_wait);
      chk($sformatf("tab%0d_mw", i), mem_write, tab[i].x_mw);
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end
    chk("rdata_0020", cpu_rdata, 16'hBEEF);

    // CPU-only read with one-cycle return.
    preload(16'h000C, 16'h002A);
    drive(1, 1, 0, 16'h000C, 16'h0, 0, 16'h0);
    step();
    drive_idle(1);
    step();
    chk("rdata_000c", cpu_rdata, 16'h002A);

    // Video streaming: four back-to-back grants, four consecutive returns.
    sdat[0] = 16'h1111; sdat[1] = 16'h2222; sdat[2] = 16'h3333; sdat[3] = 16'h4444;
    for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), sdat[i]);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 16'h0, 16'h0, 1, 16'h0100 + 16'(i));
      step();
      chk($sformatf("stream%0d_valid", i), vid_valid, 1'b1);
      chk($sformatf("stream%0d_data", i), vid_data, sdat[i]);
    end
    drive_idle(1);
    step();
    chk("stream_end_valid", vid_valid, 1'b0);

    // Reset one cycle after a video grant: the return is dropped.
    drive(1, 0, 0, 16'h0, 16'h0, 1, 16'h0101);
    step();
    drive_idle(0);
    #1;
    chk("rst_vid_valid", vid_valid, 1'b0);
    step();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_rdata", cpu_rdata, 16'h0);
    chk("rst_run", dut.vid_run_q, 0);
    drive_idle(1);
    #1;
    chk("post_rst_valid", vid_valid, 1'b0);
    step();

    // CPU read right before reset: the captured data must not survive.
    drive(1, 1, 0, 16'h000C, 16'h0, 0, 16'h0);
    step();
    drive_idle(0);
    step();
    drive_idle(1);
    step();
    chk("rst_cpu_rdata", cpu_rdata, 16'h0);

    // Idle bus holds the last address and produces nothing.
    drive(1, 0, 0, 16'h0, 16'h0, 1, 16'h0103);
    step();
    drive_idle(1);
    repeat (3) step();
    chk("idle_addr", mem_address, 16'h0103);
    chk("idle_mw", mem_write, 1'b0);
    chk("idle_valid", vid_valid, 1'b0);
    chk("idle_run", dut.vid_run_q, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom),
            16'($urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 3) != 0, 16'($urandom_range(0, 15)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
